// File: rtl/taillight_request_sequencer_if.sv
// Raw switch inputs in, tail-light sequencer requests out.
// The front-end controller is the slave; whatever drives the switches is the master.
interface taillight_request_sequencer_if;
    logic       stalk_left;
    logic       stalk_right;
    logic       hazard_sw;
    logic       brake_pedal;
    logic       turn_left;
    logic       turn_right;
    logic       brake;
    logic [2:0] state_o;

    modport master (
        output stalk_left,
        output stalk_right,
        output hazard_sw,
        output brake_pedal,
        input  turn_left,
        input  turn_right,
        input  brake,
        input  state_o
    );

    modport slave (
        input  stalk_left,
        input  stalk_right,
        input  hazard_sw,
        input  brake_pedal,
        output turn_left,
        output turn_right,
        output brake,
        output state_o
    );
endinterface

// File: rtl/taillight_request_sequencer.sv
// Tail-light front end: synchronises and debounces the switches, arbitrates turn/hazard,
// and emits flashing turn requests plus a brake request for the tail-light sequencer.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no turn request; brake follows the pedal
// LEFT    | left stalk held: turn_left flashes, cancel counter runs
// RIGHT   | right stalk held: turn_right flashes, cancel counter runs
// HAZARD  | hazard switch on: brake flashes (pedal still honoured in OFF phase)
// LOCKOUT | stalk left on too long: no flashing until both stalks released
module taillight_request_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_ON        = 16,
    parameter int BLINK_OFF       = 16,
    parameter int CANCEL_CYCLES   = 1024
) (
    input logic                          clk,
    input logic                          rst,
    taillight_request_sequencer_if.slave bus
);

    localparam int DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BLINK_MAX = (BLINK_ON > BLINK_OFF) ? BLINK_ON : BLINK_OFF;
    localparam int BL_W      = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;
    localparam int CAN_W     = (CANCEL_CYCLES > 1) ? $clog2(CANCEL_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0]  ON_LAST  = BL_W'(BLINK_ON - 1);
    localparam logic [BL_W-1:0]  OFF_LAST = BL_W'(BLINK_OFF - 1);
    localparam logic [CAN_W-1:0] CAN_LAST = CAN_W'(CANCEL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEFT    = 3'd1,
        S_RIGHT   = 3'd2,
        S_HAZARD  = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    // Bit order for the switch vectors: {brake, hazard, right, left}
    localparam int I_LEFT   = 0;
    localparam int I_RIGHT  = 1;
    localparam int I_HAZARD = 2;
    localparam int I_BRAKE  = 3;

    logic [3:0]            raw;
    logic [3:0]            sync1;
    logic [3:0]            sync2;
    logic [3:0]            db;
    logic [3:0][DB_W-1:0]  db_cnt;

    logic left_db;
    logic right_db;
    logic hazard_db;
    logic brake_db;

    state_t            state;
    state_t            state_nx;
    logic              blink_on;
    logic              blink_on_nx;
    logic [BL_W-1:0]   blink_cnt;
    logic [BL_W-1:0]   blink_cnt_nx;
    logic [CAN_W-1:0]  cancel_cnt;
    logic [CAN_W-1:0]  cancel_cnt_nx;

    logic turn_left_q;
    logic turn_right_q;
    logic brake_q;
    logic turn_left_nx;
    logic turn_right_nx;
    logic brake_nx;

    assign raw = {bus.brake_pedal, bus.hazard_sw, bus.stalk_right, bus.stalk_left};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db     <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign left_db   = db[I_LEFT];
    assign right_db  = db[I_RIGHT];
    assign hazard_db = db[I_HAZARD];
    assign brake_db  = db[I_BRAKE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (hazard_db) begin
            state_nx = S_HAZARD;
        end else begin
            case (state)
                S_HAZARD: state_nx = S_IDLE;
                S_IDLE: begin
                    if (left_db && !right_db) begin
                        state_nx = S_LEFT;
                    end else if (right_db && !left_db) begin
                        state_nx = S_RIGHT;
                    end
                end
                S_LEFT: begin
                    if (!left_db || right_db) begin
                        state_nx = S_IDLE;
                    end else if (cancel_cnt == CAN_LAST) begin
                        state_nx = S_LOCKOUT;
                    end
                end
                S_RIGHT: begin
                    if (!right_db || left_db) begin
                        state_nx = S_IDLE;
                    end else if (cancel_cnt == CAN_LAST) begin
                        state_nx = S_LOCKOUT;
                    end
                end
                S_LOCKOUT: begin
                    if (!left_db && !right_db) begin
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Entering a flashing state restarts the blink so every flash is a fresh request.
    always_comb begin
        blink_on_nx   = 1'b1;
        blink_cnt_nx  = '0;
        cancel_cnt_nx = '0;
        if ((state_nx == S_LEFT || state_nx == S_RIGHT || state_nx == S_HAZARD)
                && state_nx == state) begin
            if (blink_on) begin
                if (blink_cnt == ON_LAST) begin
                    blink_on_nx = 1'b0;
                end else begin
                    blink_cnt_nx = blink_cnt + 1'b1;
                end
            end else begin
                if (blink_cnt == OFF_LAST) begin
                    blink_on_nx = 1'b1;
                end else begin
                    blink_on_nx  = 1'b0;
                    blink_cnt_nx = blink_cnt + 1'b1;
                end
            end
        end
        if ((state == S_LEFT || state == S_RIGHT) && state_nx == state) begin
            cancel_cnt_nx = cancel_cnt + 1'b1;
        end
    end

    always_comb begin
        turn_left_nx  = 1'b0;
        turn_right_nx = 1'b0;
        brake_nx      = brake_db;
        case (state_nx)
            S_LEFT:   turn_left_nx  = blink_on_nx;
            S_RIGHT:  turn_right_nx = blink_on_nx;
            S_HAZARD: brake_nx      = blink_on_nx | brake_db;
            default: begin
                turn_left_nx  = 1'b0;
                turn_right_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_on     <= 1'b1;
            blink_cnt    <= '0;
            cancel_cnt   <= '0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
            brake_q      <= 1'b0;
        end else begin
            blink_on     <= blink_on_nx;
            blink_cnt    <= blink_cnt_nx;
            cancel_cnt   <= cancel_cnt_nx;
            turn_left_q  <= turn_left_nx;
            turn_right_q <= turn_right_nx;
            brake_q      <= brake_nx;
        end
    end

    assign bus.turn_left  = turn_left_q;
    assign bus.turn_right = turn_right_q;
    assign bus.brake      = brake_q;
    assign bus.state_o    = state;

endmodule
